// File: rtl/mmio_timer_pkg.sv
// Shared definitions for mmio_timer: register offsets, CTRL field layout,
// mode and FSM encodings, and the Timer0/Timer1 bus windows.
package mmio_timer_pkg;

   localparam logic [1:0] CTRL_OFF   = 2'd0;
   localparam logic [1:0] PRESET_OFF = 2'd1;
   localparam logic [1:0] COUNT_OFF  = 2'd2;
   localparam logic [1:0] RSVD_OFF   = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_RELOAD  = 2'b01,
      MODE_RSVD_2  = 2'b10,
      MODE_RSVD_3  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CNT  = 2'b01,
      ST_INT  = 2'b10
   } state_e;

   localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
   localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

   // Window decode used by the bus bridge: bit0 hits Timer0, bit1 hits Timer1.
   function automatic logic [1:0] timer_select(input logic [31:0] byte_addr);
      logic [1:0] hit;
      hit[0] = (byte_addr[31:4] == TIMER0_BASE[31:4]);
      hit[1] = (byte_addr[31:4] == TIMER1_BASE[31:4]);
      return hit;
   endfunction

   function automatic logic [31:0] ctrl_word(input logic en, input mode_e mode, input logic im);
      logic [31:0] w;
      w = '0;
      w[CTRL_EN]                   = en;
      w[CTRL_MODE_HI:CTRL_MODE_LO] = mode;
      w[CTRL_IM]                   = im;
      return w;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with a level interrupt.
// Define TIMER_AUTO_RELOAD_EN to store CTRL.MODE and enable auto-reload.
module mmio_timer
   import mmio_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   state_e      state;
   logic        ctrl_en;
   logic        ctrl_im;
   mode_e       ctrl_mode;
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;
   logic        unused_addr;

   assign unused_addr = ^addr[31:4];

`ifndef TIMER_AUTO_RELOAD_EN
   assign ctrl_mode = MODE_ONESHOT;
`endif

   // NOTE: non-blocking assignments throughout; the CPU write below is placed
   // after the FSM so its CTRL/irq_flag updates override the FSM's on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ctrl_en  <= 1'b0;
         ctrl_im  <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
         ctrl_mode <= MODE_ONESHOT;
`endif
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ctrl_en) begin
                  count <= preset;
                  state <= ST_CNT;
               end
            end
            ST_CNT: begin
               if (!ctrl_en) begin
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count    <= '0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            ST_INT: begin
               state <= ST_IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
               if (ctrl_mode == MODE_RELOAD) begin
                  irq_flag <= 1'b0;
               end else begin
                  ctrl_en <= 1'b0;
               end
`else
               ctrl_en <= 1'b0;
`endif
            end
            default: state <= ST_IDLE;
         endcase

         if (we) begin
            case (addr[3:2])
               CTRL_OFF: begin
                  ctrl_en  <= din[CTRL_EN];
                  ctrl_im  <= din[CTRL_IM];
`ifdef TIMER_AUTO_RELOAD_EN
                  ctrl_mode <= mode_e'(din[CTRL_MODE_HI:CTRL_MODE_LO]);
`endif
                  irq_flag <= 1'b0;
               end
               PRESET_OFF: preset <= din;
               default: ;
            endcase
         end
      end
   end

   // NOTE: dout gets a default before the case so no latch is inferred.
   always_comb begin
      dout = '0;
      case (addr[3:2])
         CTRL_OFF:   dout = ctrl_word(ctrl_en, ctrl_mode, ctrl_im);
         PRESET_OFF: dout = preset;
         COUNT_OFF:  dout = count;
         RSVD_OFF:   dout = '0;
         default:    dout = '0;
      endcase
   end

   assign irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed test-plan sequences followed by
// randomized register traffic, all compared against a behavioural timer model.
module tb_mmio_timer;

`ifdef TIMER_AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   mmio_timer dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model. phase: 0 = waiting for enable, 1 = counting down,
   // 2 = just expired (one cycle of interrupt handling).
   bit        m_en, m_im, m_flag;
   bit [1:0]  m_mode;
   bit [31:0] m_preset, m_count;
   int        m_phase;

   function automatic logic [31:0] model_read(input bit [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_im, m_mode, m_en};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit w, input bit [1:0] a, input bit [31:0] d);
      bit        en_n   = m_en;
      bit        im_n   = m_im;
      bit        flag_n = m_flag;
      bit [1:0]  mode_n = m_mode;
      bit [31:0] pre_n  = m_preset;
      bit [31:0] cnt_n  = m_count;
      int        ph_n   = m_phase;
      if (rst) begin
         en_n = 0; im_n = 0; flag_n = 0; mode_n = 0; pre_n = 0; cnt_n = 0; ph_n = 0;
      end else begin
         if (m_phase == 0) begin
            if (m_en) begin
               cnt_n = m_preset;
               ph_n  = 1;
            end
         end else if (m_phase == 1) begin
            if (!m_en) ph_n = 0;
            else if (m_count > 1) cnt_n = m_count - 1;
            else begin
               cnt_n = 0; flag_n = 1; ph_n = 2;
            end
         end else begin
            ph_n = 0;
            if (AUTO_RELOAD && m_mode == 2'b01) flag_n = 0;
            else en_n = 0;
         end
         if (w && a == 2'd0) begin
            en_n   = d[0];
            mode_n = AUTO_RELOAD ? d[2:1] : 2'b00;
            im_n   = d[3];
            flag_n = 0;
         end
         if (w && a == 2'd1) pre_n = d;
      end
      m_en = en_n; m_im = im_n; m_flag = flag_n; m_mode = mode_n;
      m_preset = pre_n; m_count = cnt_n; m_phase = ph_n;
   endtask

   // One bus cycle: drive, sample at the falling edge against the model (and
   // optionally against fixed expectations), then advance the model at the rising edge.
   task automatic bus_cycle(input bit rst, input bit w, input bit [1:0] a, input bit [31:0] d,
                            input bit fixed, input logic [31:0] exp_d, input logic exp_irq,
                            input string tag);
      logic [27:0] hi;
      hi    = 28'($urandom());
      reset = rst;
      we    = w;
      addr  = {hi, a};
      din   = d;
      @(negedge clk);
      check("model_dout", dout, model_read(a));
      check("model_irq", 32'(irq), 32'(m_flag & m_im));
      if (fixed) begin
         check(tag, dout, exp_d);
         check({tag, "_irq"}, 32'(irq), 32'(exp_irq));
      end
      @(posedge clk);
      model_step(rst, w, a, d);
      #1;
   endtask

   task automatic wr(input bit [1:0] a, input bit [31:0] d);
      bus_cycle(1'b0, 1'b1, a, d, 1'b0, 32'd0, 1'b0, "wr");
   endtask

   task automatic rd(input bit [1:0] a, input logic [31:0] exp_d, input logic exp_irq, input string tag);
      bus_cycle(1'b0, 1'b0, a, 32'd0, 1'b1, exp_d, exp_irq, tag);
   endtask

   task automatic idle();
      bus_cycle(1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 32'd0, 1'b0, "idle");
   endtask

   initial begin
      reset = 1'b1;
      we    = 1'b0;
      addr  = '0;
      din   = '0;

      // Reset state
      bus_cycle(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, "rst");
      bus_cycle(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, "rst");
      for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, 1'b0, "reset_read");

      // One-shot, PRESET=5
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      for (int k = 0; k <= 6; k++)
         rd(2'd2, (k == 0) ? 32'd0 : ((k <= 5) ? 32'(6 - k) : 32'd0), k == 6, "oneshot_count");
      rd(2'd0, 32'h8, 1'b1, "oneshot_ctrl");
      wr(2'd0, 32'h8);
      rd(2'd0, 32'h8, 1'b0, "oneshot_ack");

      // Auto-reload request, PRESET=3
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      rd(2'd0, AUTO_RELOAD ? 32'hB : 32'h9, 1'b0, "reload_ctrl");
      for (int k = 1; k <= 15; k++) begin
         int m;
         m = (k - 1) % 5;
         if (AUTO_RELOAD)
            rd(2'd2, (m < 3) ? 32'(3 - m) : 32'd0, m == 3, "reload_period");
         else
            rd(2'd2, (k < 4) ? 32'(4 - k) : 32'd0, k >= 4, "reload_latched");
      end
      wr(2'd0, 32'h0);
      idle();
      idle();

      // PRESET of 0 behaves like 1
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      rd(2'd0, 32'h9, 1'b0, "zero_ctrl");
      rd(2'd2, 32'd0, 1'b0, "zero_k1");
      rd(2'd2, 32'd0, 1'b1, "zero_k2");
      rd(2'd0, 32'h8, 1'b1, "zero_done");
      wr(2'd0, 32'h8);

      // Disable freezes, re-enable reloads, PRESET write mid-count is deferred
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      rd(2'd2, 32'd0, 1'b0, "mid_k0");
      for (int k = 1; k <= 3; k++) rd(2'd2, 32'(11 - k), 1'b0, "mid_count");
      wr(2'd0, 32'h8);
      for (int j = 1; j <= 3; j++) rd(2'd2, 32'd6, 1'b0, "mid_frozen");
      wr(2'd0, 32'h9);
      rd(2'd2, 32'd6, 1'b0, "reen_k0");
      rd(2'd2, 32'd10, 1'b0, "reen_reload");
      rd(2'd2, 32'd9, 1'b0, "reen_k2");
      wr(2'd1, 32'd2);
      rd(2'd2, 32'd7, 1'b0, "preset_mid_k4");
      rd(2'd2, 32'd6, 1'b0, "preset_mid_k5");
      rd(2'd1, 32'd2, 1'b0, "preset_readback");
      wr(2'd0, 32'h8);
      idle();
      idle();

      // Reset mid-count, then writes to read-only/reserved offsets
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      idle();
      rd(2'd2, 32'd5, 1'b0, "pre_rst_k1");
      rd(2'd2, 32'd4, 1'b0, "pre_rst_k2");
      bus_cycle(1'b1, 1'b0, 2'd2, 32'd0, 1'b1, 32'd3, 1'b0, "rst_at_3");
      for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, 1'b0, "post_rst");
      wr(2'd2, 32'hFFFF);
      rd(2'd2, 32'd0, 1'b0, "count_ro");
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, 32'd0, 1'b0, "rsvd_ro");

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bit        r, w;
         bit [1:0]  a;
         bit [31:0] d;
         r = ($urandom_range(0, 199) == 0);
         w = ($urandom_range(0, 3) == 0);
         a = 2'($urandom_range(0, 3));
         case (a)
            2'd0:    d = {$urandom() & 32'hFFFF_FFFE} | 32'(($urandom_range(0, 3) != 0) ? 1 : 0);
            2'd1:    d = $urandom_range(0, 12);
            default: d = $urandom();
         endcase
         bus_cycle(r, w, a, d, 1'b0, 32'd0, 1'b0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
